// File: rtl/race_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : race_state_ctrl
// Description : Race flow controller. It sequences idle/settings, a
//               seconds countdown, racing with per-player finish latches,
//               pause, link-loss (syncing) and finish. It also tracks the
//               elapsed race seconds and the first finisher.
//               Optional build macro RACE_FINISH_TIMEOUT_EN: FINISH returns
//               to IDLE by itself after 10 seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module race_state_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int NUM_PLAYERS   = 2,
  localparam int PW           = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_p,
  input  logic                   setting_p,
  input  logic                   pause_p,
  input  logic                   is_sync,
  input  logic [NUM_PLAYERS-1:0] player_done,
  output logic [2:0]             state,
  output logic [3:0]             countdown_sec,
  output logic                   sec_tick,
  output logic [15:0]            race_sec,
  output logic [PW-1:0]          winner,
  output logic                   winner_valid
);

  localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(CLK_HZ - 1);
  localparam logic [3:0]    CD_LOAD  = 4'(COUNTDOWN_SEC);

`ifdef RACE_FINISH_TIMEOUT_EN
  localparam int TMO_CYC = 10 * CLK_HZ;
  localparam int TW      = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTING   = 3'd1,
    S_SYNCING   = 3'd2,
    S_COUNTDOWN = 3'd3,
    S_RACING    = 3'd4,
    S_PAUSE     = 3'd5,
    S_FINISH    = 3'd6
  } state_e;

  state_e                 state_q,        state_d;
  state_e                 ret_state_q,    ret_state_d;
  logic [SW-1:0]          sub_cnt_q,      sub_cnt_d;
  logic [3:0]             cd_q,           cd_d;
  logic                   tick_q,         tick_d;
  logic [15:0]            race_sec_q,     race_sec_d;
  logic [NUM_PLAYERS-1:0] fin_q,          fin_d;
  logic [PW-1:0]          winner_q,       winner_d;
  logic                   winner_valid_q, winner_valid_d;
`ifdef RACE_FINISH_TIMEOUT_EN
  logic [TW-1:0]          tmo_cnt_q,      tmo_cnt_d;
`endif

  logic [NUM_PLAYERS-1:0] new_bits;
  logic [PW-1:0]          win_sel;
  logic                   sub_wrap;

  assign sub_wrap = (sub_cnt_q == SUB_LAST);

  // Lowest index among the players whose finish latch sets this cycle
  always_comb begin
    new_bits = player_done & ~fin_q;
    win_sel  = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (new_bits[i]) win_sel = PW'(i);
    end
  end

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d        = state_q;
    ret_state_d    = ret_state_q;
    sub_cnt_d      = sub_cnt_q;
    cd_d           = cd_q;
    tick_d         = 1'b0;
    race_sec_d     = race_sec_q;
    fin_d          = fin_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
`ifdef RACE_FINISH_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
`endif

    // Remember the last "main" state so pause/sync know where to return
    if (state_q == S_IDLE || state_q == S_COUNTDOWN || state_q == S_RACING)
      ret_state_d = state_q;

    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d        = S_COUNTDOWN;
          race_sec_d     = '0;
          fin_d          = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          cd_d           = CD_LOAD;
          sub_cnt_d      = '0;
        end else if (setting_p) begin
          state_d = S_SETTING;
        end
      end

      S_SETTING: begin
        if (setting_p) state_d = S_IDLE;
      end

      S_COUNTDOWN: begin
        if (!is_sync) begin
          state_d = S_SYNCING;
        end else if (pause_p) begin
          // Sub-second counter and seconds are kept exactly as they are
          state_d = S_PAUSE;
        end else if (sub_wrap) begin
          sub_cnt_d = '0;
          tick_d    = 1'b1;
          if (cd_q <= 4'd1) begin
            cd_d    = 4'd0;
            state_d = S_RACING;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + SW'(1);
        end
      end

      S_SYNCING: begin
        if (is_sync) begin
          if (ret_state_q == S_COUNTDOWN) begin
            // A link drop invalidates the countdown; start it over
            state_d   = S_COUNTDOWN;
            cd_d      = CD_LOAD;
            sub_cnt_d = '0;
          end else if (ret_state_q == S_RACING) begin
            state_d = S_RACING;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RACING: begin
        // Finish latches track player_done every racing cycle, whatever
        // else happens, so a simultaneous pause cannot lose a finisher
        fin_d = fin_q | player_done;
        if ((new_bits != '0) && !winner_valid_q) begin
          winner_d       = win_sel;
          winner_valid_d = 1'b1;
        end
        if (&fin_d) begin
          state_d   = S_FINISH;
`ifdef RACE_FINISH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else if (!is_sync) begin
          state_d = S_SYNCING;
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end else if (sub_wrap) begin
          sub_cnt_d = '0;
          tick_d    = 1'b1;
          if (race_sec_q != 16'hFFFF) race_sec_d = race_sec_q + 16'd1;
        end else begin
          sub_cnt_d = sub_cnt_q + SW'(1);
        end
      end

      S_PAUSE: begin
        if (pause_p) state_d = ret_state_q;
      end

      S_FINISH: begin
        if (start_p) begin
          state_d = S_IDLE;
`ifdef RACE_FINISH_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards all race progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ret_state_q    <= S_IDLE;
      sub_cnt_q      <= '0;
      cd_q           <= '0;
      tick_q         <= 1'b0;
      race_sec_q     <= '0;
      fin_q          <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
`ifdef RACE_FINISH_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      sub_cnt_q      <= sub_cnt_d;
      cd_q           <= cd_d;
      tick_q         <= tick_d;
      race_sec_q     <= race_sec_d;
      fin_q          <= fin_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
`ifdef RACE_FINISH_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign state         = state_q;
  assign countdown_sec = cd_q;
  assign sec_tick      = tick_q;
  assign race_sec      = race_sec_q;
  assign winner        = winner_q;
  assign winner_valid  = winner_valid_q;

endmodule
`default_nettype wire

// File: doc/race_state_ctrl.md
RACE_STATE_CTRL -- requirements
Module: race_state_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clock cycles per second.
REQ-002 SHALL have parameter COUNTDOWN_SEC, default 3, countdown length in seconds (1..15).
REQ-003 SHALL have parameter NUM_PLAYERS, default 2, number of racers (1..8); PW = max(1,$clog2(NUM_PLAYERS)).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_p  input  1  start request, one-cycle pulse (conditioned upstream).
REQ-007 SHALL have port setting_p  input  1  settings toggle, one-cycle pulse.
REQ-008 SHALL have port pause_p  input  1  pause toggle, one-cycle pulse.
REQ-009 SHALL have port is_sync  input  1  link to peer board is up (level).
REQ-010 SHALL have port player_done  input  NUM_PLAYERS  per-player finish-line flag (level).
REQ-011 SHALL have port state  output  3  current state: IDLE=0 SETTING=1 SYNCING=2 COUNTDOWN=3 RACING=4 PAUSE=5 FINISH=6.
REQ-012 SHALL have port countdown_sec  output  4  remaining whole countdown seconds.
REQ-013 SHALL have port sec_tick  output  1  one-cycle pulse each completed second in COUNTDOWN or RACING.
REQ-014 SHALL have port race_sec  output  16  elapsed racing seconds.
REQ-015 SHALL have port winner  output  PW  index of first finisher; winner_valid output 1 marks it valid.

Function
REQ-016 SHALL register state; transitions take effect one cycle after the causing input.
REQ-017 IDLE: start_p -> COUNTDOWN (clear race_sec, winner_valid, finish latches, load countdown_sec=COUNTDOWN_SEC); else setting_p -> SETTING; start_p wins if simultaneous.
REQ-018 SETTING: setting_p -> IDLE; other inputs ignored.
REQ-019 COUNTDOWN: sub-second counter counts 0..CLK_HZ-1; at wrap sec_tick=1, countdown_sec decrements; on wrap with countdown_sec==1 -> RACING, countdown_sec=0.
REQ-020 COUNTDOWN: !is_sync -> SYNCING (priority over all); pause_p -> PAUSE preserving sub-second counter and countdown_sec.
REQ-021 SYNCING: is_sync -> return to the remembered main state; on return to COUNTDOWN, countdown restarts from COUNTDOWN_SEC, sub-second counter 0.
REQ-022 Remembered main state SHALL update whenever state is IDLE, COUNTDOWN or RACING.
REQ-023 RACING: per-player finish latch sets on player_done bit high; race_sec increments at each second wrap, saturating at 16'hFFFF.
REQ-024 First cycle any latch sets: winner=lowest set index among newly set bits, winner_valid=1; held until next start from IDLE.
REQ-025 RACING: all latches set -> FINISH; finish has priority over pause_p in the same cycle.
REQ-026 RACING: !is_sync -> SYNCING, timers frozen; priority below finish, above pause.
REQ-027 PAUSE: pause_p -> remembered main state; counters frozen; player_done ignored.
REQ-028 FINISH: start_p -> IDLE; race_sec, winner, winner_valid held.
REQ-029 sec_tick SHALL be 0 in IDLE, SETTING, SYNCING, PAUSE, FINISH; sub-second counter cleared on entry to COUNTDOWN from IDLE and to RACING.
REQ-030 Unused encoding 7 SHALL go to IDLE next cycle.

Reset
REQ-031 rst high SHALL immediately force state=IDLE, remembered state=IDLE, countdown_sec=0, sec_tick=0, race_sec=0, winner=0, winner_valid=0, all counters and latches 0.
REQ-032 Reset mid-COUNTDOWN or mid-RACING SHALL discard all progress; no output pulse on release.

Configuration
REQ-033 With RACE_FINISH_TIMEOUT_EN defined, FINISH SHALL auto-return to IDLE after 10 s (10*CLK_HZ cycles) without start_p; counter cleared on FINISH entry.
REQ-034 Without RACE_FINISH_TIMEOUT_EN, FINISH SHALL persist until start_p or rst.

Verification (CLK_HZ=10, COUNTDOWN_SEC=3, NUM_PLAYERS=2)
REQ-035 start_p in IDLE, is_sync=1 -> COUNTDOWN, countdown_sec 3,2,1 at 10-cycle ticks, RACING 30 cycles after entry.
REQ-036 pause_p at countdown cycle 15, pause_p 20 cycles later -> resumes with countdown_sec=2, RACING 15 cycles after resume.
REQ-037 is_sync=0 during RACING, race_sec=4 -> SYNCING, race_sec stays 4; is_sync=1 -> RACING.
REQ-038 player_done=2'b11 same cycle in RACING -> winner=0, winner_valid=1, FINISH next cycle.
REQ-039 player_done[1] high with pause_p same cycle while player 0 done -> FINISH, not PAUSE; winner=0.
REQ-040 FINISH, no input, macro defined -> IDLE after 100 cycles; macro undefined -> FINISH after 200 cycles.
